// File: rtl/silife_grid_sync_master.sv
// silife_grid_sync_master: link-master side of the inter-chip edge exchange.
// Shifts local edge cells and corner out LSB first and captures the neighbour's.
module silife_grid_sync_master #(
  parameter int WIDTH       = 32,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  input  logic [WIDTH-1:0] i_cells,
  input  logic             i_corner,
  output logic [WIDTH-1:0] o_cells,
  output logic             o_corner,
  output logic             o_sync_clk,
  output logic             o_sync_active,
  output logic             o_sync_out,
  input  logic             i_sync_in
);
  localparam int KW = $clog2(WIDTH) + 1;
  localparam int PW = $clog2(HALF_PERIOD);

  if (HALF_PERIOD < 4) begin : g_hp_chk
    $error("HALF_PERIOD must be at least 4");
  end
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_w_chk
    $error("WIDTH must be a power of two and at least 2");
  end

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, FINISH} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [KW-1:0] k_q, k_d, k_nx;
  logic [WIDTH:0] tx_q, tx_d, rx_q, rx_d, res_q, res_d;
  logic [1:0]    sync_q, sync_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          sclk_q, sclk_d, act_q, act_d, sout_q, sout_d;
  logic          ph_end, last;

  assign ph_end = ph_q == PW'(HALF_PERIOD - 1);
  assign last   = k_q == KW'(WIDTH);
  assign k_nx   = k_q + 1'b1;
  assign sync_d = {sync_q[0], i_sync_in};

  // Link outputs are registered and change on the edge that enters each phase.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_end ? '0 : ph_q + 1'b1;
    k_d     = k_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    act_d   = act_q;
    sout_d  = sout_q;
    case (state_q)
      IDLE: begin
        ph_d = '0;
        if (i_start) begin
          state_d = SETUP;
          tx_d    = {i_corner, i_cells};
          k_d     = '0;
          busy_d  = 1'b1;
          act_d   = 1'b1;
          sclk_d  = 1'b1;
          sout_d  = 1'b0;
        end
      end
      SETUP: if (ph_end) begin
        state_d = LOW;
        sclk_d  = 1'b0;
        sout_d  = tx_q[k_q];
      end
      LOW: if (ph_end) begin
        state_d   = HIGH;
        sclk_d    = 1'b1;
        rx_d[k_q] = sync_q[1];
      end
      HIGH: if (ph_end) begin
        if (last) state_d = HOLD;
        else begin
          state_d = LOW;
          k_d     = k_nx;
          sclk_d  = 1'b0;
          sout_d  = tx_q[k_nx];
        end
      end
      HOLD: if (ph_end) begin
        state_d = FINISH;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        act_d   = 1'b0;
        sclk_d  = 1'b0;
        sout_d  = 1'b0;
        res_d   = rx_q;
      end
      FINISH: begin
        state_d = IDLE;
        ph_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      k_q     <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      res_q   <= '0;
      sync_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      act_q   <= 1'b0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      res_q   <= res_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      act_q   <= act_d;
      sout_q  <= sout_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_cells       = res_q[WIDTH-1:0];
  assign o_corner      = res_q[WIDTH];
  assign o_sync_clk    = sclk_q;
  assign o_sync_active = act_q;
  assign o_sync_out    = sout_q;
endmodule

// File: tb/tb_silife_grid_sync_master.sv
// tb_silife_grid_sync_master: scoreboard bench with a behavioural neighbour edge model.
module tb_silife_grid_sync_master;
  localparam int W  = 32;
  localparam int HP = 4;
  localparam int B  = (2 * (W + 1) + 2) * HP;

  logic         clk = 1'b0;
  logic         reset, i_start, i_corner;
  logic [W-1:0] i_cells;
  logic         o_busy, o_done, o_corner, o_sync_clk, o_sync_active, o_sync_out;
  logic [W-1:0] o_cells;
  logic         i_sync_in = 1'b0;

  logic [W:0]   nb_tx, nb_rx;
  logic         txq[$];
  logic [W:0]   rxq[$];
  int           nk, falls, n_chk, n_pass;
  bit           armed, prev_clk;

  silife_grid_sync_master #(.WIDTH(W), .HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .i_cells(i_cells), .i_corner(i_corner), .o_cells(o_cells), .o_corner(o_corner),
    .o_sync_clk(o_sync_clk), .o_sync_active(o_sync_active), .o_sync_out(o_sync_out),
    .i_sync_in(i_sync_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Neighbour: drives its next bit on our falling edge, samples ours on our rising edge.
  always @(o_sync_clk, o_sync_active) begin
    if (!o_sync_active) begin
      nk    = 0;
      armed = 1'b0;
    end else if (!o_sync_clk && prev_clk) begin
      falls++;
      if (nk <= W) i_sync_in = nb_tx[nk];
      armed = 1'b1;
    end else if (o_sync_clk && !prev_clk && armed) begin
      if (nk <= W) nb_rx[nk] = o_sync_out;
      if (txq.size() > 0) check("tx_bit", o_sync_out, txq.pop_front());
      nk++;
      armed = 1'b0;
    end
    prev_clk = o_sync_clk;
  end

  task automatic run_txn(input logic [W-1:0] c, input logic cr, input logic [W-1:0] nc,
                         input logic ncr, input int poke, input bit chg);
    int cyc, f0;
    @(negedge clk);
    i_cells = c;
    i_corner = cr;
    i_start = 1'b1;
    nb_tx = {ncr, nc};
    f0 = falls;
    for (int i = 0; i <= W; i++) txq.push_back(i < W ? c[i] : cr);
    rxq.push_back({ncr, nc});
    @(posedge clk); #1;
    i_start = 1'b0;
    if (chg) begin
      i_cells = '1;
      i_corner = 1'b1;
    end
    check("busy_rise", {o_busy, o_sync_active, o_sync_clk, o_done}, 4'b1110);
    cyc = 0;
    while (!o_done && cyc < 4 * B) begin
      @(posedge clk); #1;
      cyc++;
      i_start = (cyc == poke);
    end
    i_start = 1'b0;
    check("busy_len", cyc, B);
    check("done_links", {o_busy, o_sync_active, o_sync_clk, o_sync_out}, 4'b0000);
    if (rxq.size() > 0) check("rx_cells", {o_corner, o_cells}, rxq.pop_front());
    check("nb_rx", nb_rx, {cr, c});
    check("falls", falls - f0, W + 1);
    check("txq_drained", txq.size(), 0);
    @(posedge clk); #1;
    check("done_pulse", o_done, 1'b0);
  endtask

  initial begin
    int cyc, nd, last;
    bit bad;
    reset = 1'b1;
    i_start = 1'b0;
    i_cells = '0;
    i_corner = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", {o_busy, o_done, o_sync_clk, o_sync_active, o_sync_out, o_corner, o_cells}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {o_busy, o_sync_active, o_sync_clk}, 3'b000);

    run_txn(32'h0000_000B, 1'b1, 32'h0000_0006, 1'b0, -1, 1'b0);
    run_txn($urandom, 1'b0, $urandom, 1'b1, -1, 1'b0);
    run_txn('1, 1'b1, '0, 1'b0, -1, 1'b0);

    // start pulsed during LOW of bit 2 must be ignored
    run_txn($urandom, 1'b1, $urandom, 1'b1, 21, 1'b0);
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_busy || o_done) bad = 1'b1;
    end
    check("no_queued_start", bad, 1'b0);

    run_txn('0, 1'b0, 32'hA5A5_3C3C, 1'b1, -1, 1'b1);

    // reset during HIGH of bit 1
    @(negedge clk);
    i_cells = $urandom;
    i_start = 1'b1;
    nb_tx = {1'b1, 32'h1234_5678};
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre_abort_clk", {o_sync_clk, o_sync_active}, 2'b11);
    reset = 1'b1;
    #1;
    check("abort_async", {o_busy, o_done, o_sync_clk, o_sync_active, o_sync_out, o_corner, o_cells}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_done || o_busy) bad = 1'b1;
    end
    check("abort_no_done", bad, 1'b0);
    check("abort_cells", {o_corner, o_cells}, 0);
    run_txn($urandom, 1'b1, $urandom, 1'b0, -1, 1'b0);

    // start held high: three back-to-back transactions
    @(negedge clk);
    i_cells = $urandom;
    i_corner = 1'b0;
    nb_tx = {1'b1, 32'hDEAD_BEEF};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i <= W; i++) txq.push_back(i < W ? i_cells[i] : i_corner);
      rxq.push_back(nb_tx);
    end
    i_start = 1'b1;
    cyc = 0;
    nd = 0;
    last = 0;
    while (nd < 3 && cyc < 4 * B) begin
      @(posedge clk); #1;
      cyc++;
      if (o_done) begin
        if (rxq.size() > 0) check("held_cells", {o_corner, o_cells}, rxq.pop_front());
        if (nd > 0) check("held_spacing", cyc - last, B + 2);
        last = cyc;
        nd++;
        if (nd == 3) i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    check("held_count", nd, 3);
    repeat (4) @(posedge clk);
    #1;
    check("held_idle", {o_busy, o_sync_active}, 2'b00);
    check("held_txq", txq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
